// File: rtl/ram_pattern_checker.sv
// rtl/ram_pattern_checker.sv - write/read-back pattern sequencer and checker for a 512x48 RAM
module ram_pattern_checker #(
    parameter int                ADDR_W     = 9,
    parameter int                DATA_W     = 48,
    parameter int                DEPTH      = 512,
    parameter int                RD_LATENCY = 1,
    parameter logic [DATA_W-1:0] SEED       = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_waddr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_re_o,
    output logic [ADDR_W-1:0] ram_raddr_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [15:0]       err_cnt_o,
    output logic [ADDR_W-1:0] first_err_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_DRAIN = ADDR_W'(RD_LATENCY - 1);

    // Address-derived pattern: address in the top bits and the bottom bits, masked by SEED.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] ax;
        ax = DATA_W'(a);
        return SEED ^ (ax << (DATA_W - ADDR_W)) ^ ax;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                re_q, re_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   first_err_q, first_err_d;
    logic                pipe_vld_q  [RD_LATENCY];
    logic                pipe_vld_d  [RD_LATENCY];
    logic [ADDR_W-1:0]   pipe_addr_q [RD_LATENCY];
    logic [ADDR_W-1:0]   pipe_addr_d [RD_LATENCY];
    logic                mismatch;
    logic                start_ok;

    // Outputs lag the state by one cycle, so IDLE coincides with the done pulse; a start
    // seen while done is high is dropped so runs never overlap.
    assign start_ok = (state_q == S_IDLE) && start_i && !done_q;

    // State register and phase address counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: walk every address in WRITE then READ, then wait out the read latency.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_WRITE;
                    cnt_d   = '0;
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end
            end
            S_READ: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_DRAIN) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values: RAM drive, compare pipeline, error bookkeeping.
    always_comb begin
        we_d    = (state_q == S_WRITE);
        waddr_d = we_d ? cnt_q : waddr_q;
        wdata_d = we_d ? pattern(cnt_q) : wdata_q;
        re_d    = (state_q == S_READ);
        raddr_d = re_d ? cnt_q : raddr_q;
        busy_d  = (state_q != S_IDLE);
        done_d  = (state_q == S_DONE);

        pipe_vld_d[0]  = re_q;
        pipe_addr_d[0] = raddr_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end

        mismatch = pipe_vld_q[RD_LATENCY-1] &&
                   (ram_rdata_i != pattern(pipe_addr_q[RD_LATENCY-1]));

        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;
        if (start_ok) begin
            err_cnt_d   = '0;
            first_err_d = '0;
            pass_d      = 1'b0;
        end else if (mismatch) begin
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
            if (err_cnt_q == 16'd0) begin
                first_err_d = pipe_addr_q[RD_LATENCY-1];
            end
        end
        // The final compare lands on the same edge, so judge the updated count.
        if (state_q == S_DONE) begin
            pass_d = (err_cnt_d == 16'd0);
        end
    end

    // Registered outputs and compare pipeline; reset flushes everything.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            re_q        <= 1'b0;
            raddr_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_addr_q[i] <= '0;
            end
        end else begin
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            re_q        <= re_d;
            raddr_q     <= raddr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_d[i];
                pipe_addr_q[i] <= pipe_addr_d[i];
            end
        end
    end

    assign ram_we_o         = we_q;
    assign ram_waddr_o      = waddr_q;
    assign ram_wdata_o      = wdata_q;
    assign ram_re_o         = re_q;
    assign ram_raddr_o      = raddr_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_q;

endmodule

// File: tb/tb_ram_pattern_checker.sv
// tb/tb_ram_pattern_checker.sv - randomized model-checked bench for ram_pattern_checker
module tb_ram_pattern_checker;

    localparam int          D     = 512;
    localparam logic [47:0] SEED1 = 48'hA5A5_A5A5_A5A5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start   [2];
    logic        we      [2];
    logic [8:0]  waddr   [2];
    logic [47:0] wdata   [2];
    logic        re      [2];
    logic [8:0]  raddr   [2];
    logic [47:0] rdata   [2];
    logic        busy    [2];
    logic        done    [2];
    logic        pass    [2];
    logic [15:0] err_cnt [2];
    logic [8:0]  first_err [2];

    ram_pattern_checker u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start[0]),
        .ram_we_o(we[0]), .ram_waddr_o(waddr[0]), .ram_wdata_o(wdata[0]),
        .ram_re_o(re[0]), .ram_raddr_o(raddr[0]), .ram_rdata_i(rdata[0]),
        .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]),
        .err_cnt_o(err_cnt[0]), .first_err_addr_o(first_err[0])
    );

    ram_pattern_checker #(.RD_LATENCY(3), .SEED(SEED1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start[1]),
        .ram_we_o(we[1]), .ram_waddr_o(waddr[1]), .ram_wdata_o(wdata[1]),
        .ram_re_o(re[1]), .ram_raddr_o(raddr[1]), .ram_rdata_i(rdata[1]),
        .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]),
        .err_cnt_o(err_cnt[1]), .first_err_addr_o(first_err[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [47:0] mem     [2][D];
    logic [47:0] fault   [2][D];
    logic [47:0] rd_pipe [2][4];
    int          ram_lat [2];

    int          t     [2] = '{-1, -1};
    int          n_acc [2] = '{0, 0};
    int          n_done[2] = '{0, 0};
    logic [15:0] x_err   [2];
    logic [8:0]  x_first [2];
    logic        x_pass  [2];
    bit          x_ok    [2];
    logic [8:0]  m_waddr [2];
    logic [8:0]  m_raddr [2];
    logic [47:0] m_wdata [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int done_t(input int i);
        return 2 * D + lat_of(i) + 1;
    endfunction

    function automatic logic [47:0] pattern(input int i, input logic [8:0] a);
        logic [47:0] ax;
        ax = 48'(a);
        return ((i == 0) ? 48'h0 : SEED1) ^ (ax << 39) ^ ax;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // RAM model: RD_LATENCY-stage registered read, with per-word XOR fault masks on read.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 3; j > 0; j--) rd_pipe[i][j] <= rd_pipe[i][j-1];
            rd_pipe[i][0] <= mem[i][raddr[i]] ^ fault[i][raddr[i]];
            if (we[i]) mem[i][waddr[i]] <= wdata[i];
        end
    end
    assign rdata[0] = rd_pipe[0][ram_lat[0]-1];
    assign rdata[1] = rd_pipe[1][ram_lat[1]-1];

    // Run-position model: edges since the accepted start, and the outcome the run must report.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                t[i] = -1; x_err[i] = '0; x_first[i] = '0; x_pass[i] = 1'b0; x_ok[i] = 1'b1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (t[i] >= 0) t[i]++;
                if ((t[i] < 0 || t[i] >= done_t(i) + 2) && start[i]) begin
                    int cnt;
                    bit found;
                    t[i] = 0;
                    n_acc[i]++;
                    cnt = 0; found = 0; x_first[i] = '0;
                    for (int a = 0; a < D; a++) begin
                        if (fault[i][a] != '0) begin
                            cnt++;
                            if (!found) begin x_first[i] = 9'(a); found = 1; end
                        end
                    end
                    x_err[i]  = 16'(cnt);
                    x_pass[i] = (cnt == 0);
                    x_ok[i]   = (ram_lat[i] == lat_of(i));
                end
            end
        end
    end

    int tt, dt;
    // Compare process: every output of both DUTs against the model each cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_waddr[i] = '0; m_raddr[i] = '0; m_wdata[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                tt = t[i];
                dt = done_t(i);
                if (tt >= 1 && tt <= D) begin
                    m_waddr[i] = 9'(tt - 1);
                    m_wdata[i] = pattern(i, 9'(tt - 1));
                end
                if (tt >= D + 1 && tt <= 2 * D) m_raddr[i] = 9'(tt - D - 1);
                chk($sformatf("we%0d", i),    we[i],    (tt >= 1 && tt <= D));
                chk($sformatf("waddr%0d", i), waddr[i], m_waddr[i]);
                chk($sformatf("wdata%0d", i), wdata[i], m_wdata[i]);
                chk($sformatf("re%0d", i),    re[i],    (tt >= D + 1 && tt <= 2 * D));
                chk($sformatf("raddr%0d", i), raddr[i], m_raddr[i]);
                chk($sformatf("busy%0d", i),  busy[i],  (tt >= 1 && tt <= dt));
                chk($sformatf("done%0d", i),  done[i],  (tt == dt));
                if (tt == 1) begin
                    chk($sformatf("err_clr%0d", i),   err_cnt[i],   16'd0);
                    chk($sformatf("first_clr%0d", i), first_err[i], 9'd0);
                end
                if (tt >= 1 && tt < dt) chk($sformatf("pass_run%0d", i), pass[i], 1'b0);
                if ((tt < 0 || tt >= dt) && x_ok[i]) begin
                    chk($sformatf("pass%0d", i),  pass[i],      x_pass[i]);
                    chk($sformatf("err%0d", i),   err_cnt[i],   x_err[i]);
                    chk($sformatf("first%0d", i), first_err[i], x_first[i]);
                end
                if (done[i] === 1'b1) n_done[i]++;
            end
            if (we[0] === 1'b1 && waddr[0] == 9'd3)   chk("wdata_a3",   wdata[0], 48'h0180_0000_0003);
            if (we[0] === 1'b1 && waddr[0] == 9'd511) chk("wdata_a511", wdata[0], 48'hFF80_0000_01FF);
        end
    end

    // One start pulse, optional extra pulses at given edges; returns edges until done_o.
    task automatic run_wait(input int i, input int pa, input int pb, output int cyc);
        @(negedge clk); start[i] = 1'b1;
        @(negedge clk); start[i] = 1'b0;
        cyc = 0;
        while (done[i] !== 1'b1 && cyc < 3000) begin
            start[i] = (cyc == pa - 1) || (cyc == pb - 1);
            @(negedge clk);
            cyc++;
        end
        start[i] = 1'b0;
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < D; a++) fault[i][a] = '0;
    endtask

    int cyc, a0, d0, nf;

    initial begin
        clear_faults();
        ram_lat[0] = 1; ram_lat[1] = 3;
        start[0] = 1'b0; start[1] = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", busy[i], 1'b0);
            chk("rst_done", done[i], 1'b0);
            chk("rst_pass", pass[i], 1'b0);
            chk("rst_err",  err_cnt[i], 16'd0);
            chk("rst_we",   we[i], 1'b0);
            chk("rst_re",   re[i], 1'b0);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_wait(0, -1, -1, cyc);
        chk("clean_done_cycle", cyc, 1026);
        chk("clean_pass", pass[0], 1'b1);
        chk("clean_err", err_cnt[0], 16'd0);

        fault[0][7] = 48'h1;
        run_wait(0, -1, -1, cyc);
        chk("stuck_err", err_cnt[0], 16'd1);
        chk("stuck_first", first_err[0], 9'd7);
        chk("stuck_pass", pass[0], 1'b0);
        clear_faults();

        run_wait(0, -1, -1, cyc);
        chk("restart_err", err_cnt[0], 16'd0);
        chk("restart_pass", pass[0], 1'b1);

        fault[0][20] = 48'h8000_0000_0000; fault[0][5] = 48'h10; fault[0][300] = 48'hF0;
        run_wait(0, -1, -1, cyc);
        chk("multi_err", err_cnt[0], 16'd3);
        chk("multi_first", first_err[0], 9'd5);
        chk("multi_pass", pass[0], 1'b0);
        clear_faults();

        for (int r = 0; r < 3; r++) begin
            nf = $urandom_range(0, 6);
            for (int k = 0; k < nf; k++)
                fault[0][$urandom_range(0, D - 1)] = 48'({$urandom, $urandom}) | 48'h1;
            run_wait(0, -1, -1, cyc);
            chk("rand_done_cycle", cyc, 1026);
            clear_faults();
        end

        run_wait(1, -1, -1, cyc);
        chk("lat3_done_cycle", cyc, 1028);
        chk("lat3_pass", pass[1], 1'b1);
        chk("lat3_err", err_cnt[1], 16'd0);

        for (int k = 0; k < 4; k++)
            fault[1][$urandom_range(0, D - 1)] = 48'({$urandom, $urandom}) | 48'h1;
        run_wait(1, -1, -1, cyc);
        chk("lat3_rand_done_cycle", cyc, 1028);
        clear_faults();

        ram_lat[1] = 2;
        run_wait(1, -1, -1, cyc);
        chk("lat_mismatch_err", (err_cnt[1] >= 16'd511), 1'b1);
        chk("lat_mismatch_pass", pass[1], 1'b0);
        repeat (4) @(negedge clk);
        ram_lat[1] = 3;

        a0 = n_acc[0]; d0 = n_done[0];
        run_wait(0, 10, 600, cyc);
        chk("pulse_done_cycle", cyc, 1026);
        repeat (10) @(negedge clk);
        chk("pulse_acc", n_acc[0] - a0, 1);
        chk("pulse_dones", n_done[0] - d0, 1);

        a0 = n_acc[0]; d0 = n_done[0];
        @(negedge clk); start[0] = 1'b1;
        repeat (2200) @(negedge clk);
        start[0] = 1'b0;
        repeat (1000) @(negedge clk);
        chk("held_acc", n_acc[0] - a0, 3);
        chk("held_dones", n_done[0] - d0, 3);
        chk("held_idle", busy[0], 1'b0);

        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        repeat (700) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", we[0], 1'b0);
        chk("mid_rst_re", re[0], 1'b0);
        chk("mid_rst_raddr", raddr[0], 9'd0);
        chk("mid_rst_waddr", waddr[0], 9'd0);
        chk("mid_rst_wdata", wdata[0], 48'd0);
        chk("mid_rst_busy", busy[0], 1'b0);
        chk("mid_rst_done", done[0], 1'b0);
        chk("mid_rst_err", err_cnt[0], 16'd0);
        chk("mid_rst_pass", pass[0], 1'b0);
        chk("mid_rst_first", first_err[0], 9'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run_wait(0, -1, -1, cyc);
        chk("post_rst_done_cycle", cyc, 1026);
        chk("post_rst_pass", pass[0], 1'b1);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
